// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// serial_frame_rx_if : serial line in, deframed word and status out
// Optional ErrCnt port follows SERIAL_RX_ERRCNT_EN.       Rev 1.0
// ============================================================================
interface serial_frame_rx_if #(
    parameter int DATA_W = 4
);
    logic              SerialDin;
    logic [DATA_W-1:0] ParallelDout;
    logic              DoutValid;
    logic              ParityErr;
    logic              FrameErr;
    logic              Busy;
`ifdef SERIAL_RX_ERRCNT_EN
    logic [7:0]        ErrCnt;

    modport master (output SerialDin,
                    input  ParallelDout, DoutValid, ParityErr, FrameErr, Busy, ErrCnt);
    modport slave  (input  SerialDin,
                    output ParallelDout, DoutValid, ParityErr, FrameErr, Busy, ErrCnt);
`else
    modport master (output SerialDin,
                    input  ParallelDout, DoutValid, ParityErr, FrameErr, Busy);
    modport slave  (input  SerialDin,
                    output ParallelDout, DoutValid, ParityErr, FrameErr, Busy);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// serial_frame_rx : start / DATA_W bits MSB first / even parity / stop=0 deframer
// Optional saturating error counter under SERIAL_RX_ERRCNT_EN.   Rev 1.0
// ============================================================================
module serial_frame_rx #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 3
) (
    input  wire logic         Clk,
    input  wire logic         Rst_n,
    serial_frame_rx_if.slave  rx
);
    localparam logic [1:0]       c_IDLE   = 2'd0;
    localparam logic [1:0]       c_DATA   = 2'd1;
    localparam logic [1:0]       c_PARITY = 2'd2;
    localparam logic [1:0]       c_STOP   = 2'd3;
    localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              par_q;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q, perr_q, ferr_q, busy_q;

    logic              w_start, w_shift, w_par_en, w_stop;
    logic              w_perr, w_ferr;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= c_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (rx.SerialDin)     state_d = c_DATA;
            c_DATA:   if (cnt_q == c_LAST)  state_d = c_PARITY;
            c_PARITY:                       state_d = c_STOP;
            c_STOP:                         state_d = c_IDLE;
            default:                        state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_start  = (state_q == c_IDLE) && rx.SerialDin;
        w_shift  = (state_q == c_DATA);
        w_par_en = (state_q == c_PARITY);
        w_stop   = (state_q == c_STOP);
        // Even parity over data plus P must be 0; the stop bit must be 0.
        w_perr   = (^shift_q) ^ par_q;
        w_ferr   = rx.SerialDin;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= (state_d != c_IDLE);
            if (w_start) cnt_q <= '0;
            if (w_shift) begin
                shift_q <= {shift_q[DATA_W-2:0], rx.SerialDin};
                cnt_q   <= cnt_q + 1'b1;
            end
            if (w_par_en) par_q <= rx.SerialDin;
            if (w_stop) begin
                dout_q  <= shift_q;
                perr_q  <= w_perr;
                ferr_q  <= w_ferr;
                valid_q <= 1'b1;
            end
        end
    end

`ifdef SERIAL_RX_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            errcnt_q <= 8'd0;
        else if (w_stop && (w_perr || w_ferr) && (errcnt_q != 8'hFF))
            errcnt_q <= errcnt_q + 8'd1;
    end

    assign rx.ErrCnt = errcnt_q;
`endif

    assign rx.ParallelDout = dout_q;
    assign rx.DoutValid    = valid_q;
    assign rx.ParityErr    = perr_q;
    assign rx.FrameErr     = ferr_q;
    assign rx.Busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// tb_serial_frame_rx : random and directed frames against a stream-parsing model
// Rev 1.0
// ============================================================================
module tb_serial_frame_rx;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 3;
    localparam int MAXN   = 4096;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .rx    (bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    bit stim[$];

    logic [DATA_W-1:0] m_dout;
    bit                m_perr, m_ferr;
    int                m_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_errcnt(input string tag);
`ifdef SERIAL_RX_ERRCNT_EN
        check(tag, 32'(bus.ErrCnt), 32'(m_cnt));
`else
        if (tag.len() == 0) n_checks += 0;
`endif
    endtask

    task automatic add_frame(input logic [DATA_W-1:0] d, input bit inj, input bit stop, input int gap);
        stim.push_back(1'b1);
        for (int k = DATA_W - 1; k >= 0; k--) stim.push_back(d[k]);
        stim.push_back((^d) ^ inj);
        stim.push_back(stop);
        for (int k = 0; k < gap; k++) stim.push_back(1'b0);
    endtask

    // Model: parse the whole bit stream into frames, then drive it and compare cycle by cycle.
    task automatic run_stream();
        bit                vld [MAXN];
        bit                bsy [MAXN];
        logic [DATA_W-1:0] fw  [MAXN];
        bit                fpe [MAXN];
        bit                ffe [MAXN];
        int                n, i, last;
        logic [DATA_W-1:0] d;
        n = stim.size();
        for (int t = 0; t < MAXN; t++) begin
            vld[t] = 0; bsy[t] = 0; fw[t] = '0; fpe[t] = 0; ffe[t] = 0;
        end
        i = 0;
        while (i < n) begin
            if (stim[i] && (i + DATA_W + 2 < n)) begin
                for (int k = 0; k < DATA_W; k++) d[DATA_W-1-k] = stim[i+1+k];
                last = i + DATA_W + 2;
                for (int j = i; j < last; j++) bsy[j] = 1;
                vld[last] = 1;
                fw[last]  = d;
                fpe[last] = (^d) ^ stim[i+DATA_W+1];
                ffe[last] = stim[last];
                i = last + 1;
            end else begin
                i++;
            end
        end
        for (int t = 0; t < n; t++) begin
            @(negedge Clk);
            bus.SerialDin = stim[t];
            @(posedge Clk);
            #1;
            if (vld[t]) begin
                m_dout = fw[t];
                m_perr = fpe[t];
                m_ferr = ffe[t];
                if ((fpe[t] || ffe[t]) && m_cnt < 255) m_cnt++;
            end
            check("valid", 32'(bus.DoutValid), 32'(vld[t]));
            check("busy",  32'(bus.Busy),      32'(bsy[t]));
            check("dout",  32'(bus.ParallelDout), 32'(m_dout));
            check("perr",  32'(bus.ParityErr), 32'(m_perr));
            check("ferr",  32'(bus.FrameErr),  32'(m_ferr));
            check_errcnt("errcnt");
        end
        stim.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},  32'(bus.ParallelDout), 32'd0);
        check({tag, "_valid"}, 32'(bus.DoutValid),    32'd0);
        check({tag, "_perr"},  32'(bus.ParityErr),    32'd0);
        check({tag, "_ferr"},  32'(bus.FrameErr),     32'd0);
        check({tag, "_busy"},  32'(bus.Busy),         32'd0);
        check_errcnt({tag, "_errcnt"});
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        bus.SerialDin = 1'b0;
        m_dout = '0; m_perr = 0; m_ferr = 0; m_cnt = 0;
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        // Directed frames from the test plan, then idle line.
        add_frame(4'b1010, 0, 0, 3);
        add_frame(4'b0111, 1, 0, 2);
        add_frame(4'b1100, 0, 1, 0);
        add_frame(4'b0001, 0, 0, 1);
        add_frame(4'b1111, 0, 0, 0);
        add_frame(4'b0011, 0, 0, 2);
        for (int k = 0; k < 20; k++) stim.push_back(1'b0);
        run_stream();

        // Random frames with random errors and gaps (including zero gap).
        for (int f = 0; f < 40; f++) begin
            rd = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            add_frame(rd, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                      int'($urandom_range(0, 3)));
        end
        stim.push_back(1'b0);
        run_stream();

`ifdef SERIAL_RX_ERRCNT_EN
        for (int f = 0; f < 260; f++) add_frame(DATA_W'(f), 1, 0, 0);
        for (int k = 0; k < 3; k++) stim.push_back(1'b0);
        run_stream();
        check("errcnt_sat", 32'(bus.ErrCnt), 32'd255);
`endif

        // Reset in the middle of a frame: start plus two data bits.
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            bus.SerialDin = (k == 0) ? 1'b1 : 1'(k[0]);
            @(posedge Clk);
            #1;
            check("abort_busy",  32'(bus.Busy),      32'd1);
            check("abort_valid", 32'(bus.DoutValid), 32'd0);
        end
        @(negedge Clk);
        bus.SerialDin = 1'b0;
        Rst_n = 1'b0;
        m_dout = '0; m_perr = 0; m_ferr = 0; m_cnt = 0;
        #1;
        check_all_zero("midrst");
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) stim.push_back(1'b0);
        add_frame(4'b0101, 0, 0, 3);
        run_stream();
        check("after_rst_dout", 32'(bus.ParallelDout), 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
